if_id_queue: RTL and testbench

- Instruction queue between the instruction fetch stage and decode.
- Captures each fetched (pc, instruction) pair into a small FIFO and presents the oldest entry to decode through a valid/ready handshake.
- Drives the fetch unit's stall input through in_ready: fetch stall = !in_ready.
- Supports a single-cycle flush for taken branches and jumps, when the fetch PC is redirected.

---
 rtl/if_id_queue.sv | 67 ++++++
 tb/tb_if_id_queue.sv | 139 +++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: a small FIFO of (pc, inst) pairs
// with a valid/ready handshake toward decode and a single-cycle branch flush.
module if_id_queue #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [ADDR_WIDTH-1:0]  in_pc,
  input  logic [DATA_WIDTH-1:0]  in_inst,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic [DATA_WIDTH-1:0]  out_inst,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_inst [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic                  push;
  logic                  pop;

  // Full/empty come only from the registered count, so in_ready never sees out_ready.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = count_q;

  assign out_pc   = out_valid ? mem_pc[rd_ptr]   : '0;
  assign out_inst = out_valid ? mem_inst[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage is never reset; stale slots are masked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= in_pc;
      mem_inst[wr_ptr] <= in_inst;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: a reference queue tracks expected contents
// and every cycle the DUT head, count and handshake flags are compared to it.
module tb_if_id_queue;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int D  = 4;

  logic           clk = 1'b0;
  logic           rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [AW-1:0]  in_pc, out_pc;
  logic [DW-1:0]  in_inst, out_inst;
  logic [$clog2(D):0] count;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] inst;
  } entry_t;

  entry_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  if_id_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_ready(out_ready), .count(count)
  );

  function automatic logic [DW-1:0] inst_of(input logic [AW-1:0] pc);
    return {~pc, pc} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  // One clock: drive inputs, compare at the falling edge, advance the model.
  task automatic cycle(input logic r, input logic fl, input logic v,
                       input logic [AW-1:0] pc, input logic ordy);
    logic   m_push, m_pop;
    entry_t e;
    rst = r; flush = fl; in_valid = v; in_pc = pc; in_inst = inst_of(pc); out_ready = ordy;
    @(negedge clk);
    check("count", 64'(count), 64'(sb.size()));
    check("in_ready", 64'(in_ready), 64'(sb.size() != D));
    check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("out_pc", 64'(out_pc), 64'(sb[0].pc));
      check("out_inst", 64'(out_inst), 64'(sb[0].inst));
    end else begin
      check("out_pc_idle", 64'(out_pc), 64'd0);
      check("out_inst_idle", 64'(out_inst), 64'd0);
    end
    if (r || fl) begin
      sb.delete();
    end else begin
      m_pop  = (sb.size() != 0) && ordy;
      m_push = v && (sb.size() != D);
      if (m_pop) void'(sb.pop_front());
      if (m_push) begin
        e.pc   = pc;
        e.inst = inst_of(pc);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Fill to full with decode stalled; a 5th entry is refused.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, AW'(i), 1'b0);
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_head", 64'(out_pc), 64'd0);
    cycle(1'b0, 1'b0, 1'b1, 16'd4, 1'b0);
    check("fifth_dropped", 64'(count), 64'd4);

    // Pop while full: no push that cycle, pc 4 taken on the next one.
    cycle(1'b0, 1'b0, 1'b1, 16'd4, 1'b1);
    check("full_pop_count", 64'(count), 64'd3);
    check("full_pop_head", 64'(out_pc), 64'd1);
    cycle(1'b0, 1'b0, 1'b1, 16'd4, 1'b0);
    check("refill_count", 64'(count), 64'd4);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);

    // Streaming through wrap of the pointers.
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, AW'(i), 1'b1);
    check("stream_count", 64'(count), 64'd1);
    check("stream_last", 64'(out_pc), 64'd9);
    cycle(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);

    // Flush with three queued entries, concurrent push and pop suppressed.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, AW'(16 + i), 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 16'h20, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out_pc", 64'(out_pc), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    cycle(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 16'h40, 1'b0);
    check("post_flush_head", 64'(out_pc), 64'h40);
    cycle(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);

    // Reset mid-stream drops everything, including the same-cycle push.
    cycle(1'b0, 1'b0, 1'b1, 16'h30, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 16'h31, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 16'h99, 1'b1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    cycle(1'b0, 1'b0, 1'b1, 16'd7, 1'b0);
    check("rst_push_pc", 64'(out_pc), 64'd7);
    check("rst_push_inst", 64'(out_inst), 64'(inst_of(16'd7)));
    cycle(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);

    // Decode stall holds the head stable, then advances in order.
    cycle(1'b0, 1'b0, 1'b1, 16'd5, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 16'd6, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    check("stall_head", 64'(out_pc), 64'd5);
    cycle(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    check("stall_advance", 64'(out_pc), 64'd6);
    cycle(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
